// File: rtl/ovl_width_pkg.sv
// ovl_width_pkg: shared types and constants for the multi-channel OVL width checker.
//   ch_state_e : per-channel FSM states (IDLE, HIGH, OVER)
//   COV_W      : width of each per-channel legal-pulse coverage counter
//   params_ok  : elaboration-time sanity check of the checker parameters
package ovl_width_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    OVER = 2'd2
  } ch_state_e;

  localparam int COV_W = 16;

  // True when the parameter set is usable: channel count in range, both
  // thresholds below the counter's top value, and MAX not below MIN when
  // both checks are active.
  function automatic bit params_ok(input int num_ch, input int min_cks,
                                   input int max_cks, input int cnt_w);
    longint lim;
    lim = (longint'(1) << cnt_w) - 1;
    params_ok = 1'b1;
    if (num_ch < 1 || num_ch > 32)                         params_ok = 1'b0;
    if (cnt_w < 1 || cnt_w > 30)                           params_ok = 1'b0;
    if (longint'(min_cks) >= lim)                          params_ok = 1'b0;
    if (longint'(max_cks) >= lim)                          params_ok = 1'b0;
    if (min_cks < 0 || max_cks < 0)                        params_ok = 1'b0;
    if (min_cks != 0 && max_cks != 0 && max_cks < min_cks) params_ok = 1'b0;
  endfunction

endpackage

// File: rtl/ovl_width_ch.sv
// ovl_width_ch: one channel of the width checker.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   enable       : checker enable; low forces IDLE and discards any pulse
//   test_expr    : monitored signal (X/Z behaves as 0)
//   fire_min     : registered 1-cycle pulse, a pulse shorter than MIN_CKS ended
//   fire_max     : registered 1-cycle pulse, a pulse ran past MAX_CKS
//   cov_pulses   : legal-pulse counter (saturating), zero unless OVL_WIDTH_COV_EN
//   state        : current FSM state, exported for checker binding
// Optional feature macro: OVL_WIDTH_COV_EN enables the coverage counter.
//
// Handshake note: this block has no valid/ready interface; every input is
// sampled on each rising clock edge.
module ovl_width_ch
  import ovl_width_pkg::*;
#(
  parameter int MIN_CKS = 3,
  parameter int MAX_CKS = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             test_expr,
  output logic             fire_min,
  output logic             fire_max,
  output logic [COV_W-1:0] cov_pulses,
  output ch_state_e        state
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CKS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CKS);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_min_q, fire_min_d;
  logic             fire_max_q, fire_max_d;
  logic             min_short;
  logic             max_hit;

  // A zero threshold disables its check entirely.
  if (MIN_CKS != 0) begin : g_min
    assign min_short = (cnt_q < MIN_C);
  end else begin : g_no_min
    assign min_short = 1'b0;
  end

  if (MAX_CKS != 0) begin : g_max
    assign max_hit = (cnt_q == MAX_C);
  end else begin : g_no_max
    assign max_hit = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fire_min_d = 1'b0;
    fire_max_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (test_expr) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        HIGH: begin
          if (test_expr) begin
            if (max_hit) begin
              fire_max_d = 1'b1;
              state_d    = OVER;
            end else if (cnt_q != '1) begin
              // Saturate so an unbounded pulse (MAX_CKS=0) cannot wrap.
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            fire_min_d = min_short;
            state_d    = IDLE;
            cnt_d      = '0;
          end
        end
        OVER: begin
          // Already reported; the tail of the pulse is ignored.
          if (!test_expr) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fire_min_q <= 1'b0;
      fire_max_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fire_min_q <= fire_min_d;
      fire_max_q <= fire_max_d;
    end
  end

  assign fire_min = fire_min_q;
  assign fire_max = fire_max_q;
  assign state    = state_q;

`ifdef OVL_WIDTH_COV_EN
  logic             legal_end;
  logic [COV_W-1:0] cov_q, cov_d;

  always_comb begin
    legal_end = enable && (state_q == HIGH) && !test_expr && !min_short;
    cov_d     = cov_q;
    if (legal_end && (cov_q != '1)) cov_d = cov_q + COV_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cov_q <= '0;
    else       cov_q <= cov_d;
  end

  assign cov_pulses = cov_q;
`else
  assign cov_pulses = '0;
`endif

endmodule

// File: rtl/ovl_width_mc.sv
// ovl_width_mc: multi-channel OVL pulse-width checker.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   enable       : global checker enable
//   test_expr    : NUM_CH monitored lines, one per channel
//   clr_status   : synchronous clear of err_status (a same-cycle set wins)
//   fire_min     : per-channel 1-cycle pulse, short pulse ended
//   fire_max     : per-channel 1-cycle pulse, pulse exceeded MAX_CKS
//   fire         : OR of all fire_min/fire_max bits, same cycle
//   err_status   : sticky per-channel violation flags
//   cov_pulses   : NUM_CH x 16-bit legal-pulse counters (OVL_WIDTH_COV_EN)
// Optional feature macro: OVL_WIDTH_COV_EN.
module ovl_width_mc
  import ovl_width_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MIN_CKS = 3,
  parameter int MAX_CKS = 5,
  parameter int CNT_W   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       test_expr,
  input  logic                    clr_status,
  output logic [NUM_CH-1:0]       fire_min,
  output logic [NUM_CH-1:0]       fire_max,
  output logic                    fire,
  output logic [NUM_CH-1:0]       err_status,
  output logic [NUM_CH*COV_W-1:0] cov_pulses
);

  if (!params_ok(NUM_CH, MIN_CKS, MAX_CKS, CNT_W)) begin : g_bad_params
    $error("ovl_width_mc: illegal NUM_CH/MIN_CKS/MAX_CKS/CNT_W combination");
  end

  // Per-channel FSM state, kept visible for bound checkers.
  ch_state_e ch_state [NUM_CH];

  logic [NUM_CH-1:0] err_status_q, err_status_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ovl_width_ch #(
      .MIN_CKS (MIN_CKS),
      .MAX_CKS (MAX_CKS),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .test_expr  (test_expr[i]),
      .fire_min   (fire_min[i]),
      .fire_max   (fire_max[i]),
      .cov_pulses (cov_pulses[i*COV_W +: COV_W]),
      .state      (ch_state[i])
    );
  end

  assign fire = |{fire_min, fire_max};

  // Clear first, then OR in new fires so a same-cycle set survives the clear.
  always_comb begin
    err_status_d = clr_status ? '0 : err_status_q;
    err_status_d = err_status_d | fire_min | fire_max;
  end

  always_ff @(posedge clock) begin
    if (reset) err_status_q <= '0;
    else       err_status_q <= err_status_d;
  end

  assign err_status = err_status_q;

endmodule

// File: tb/tb_ovl_width_mc.sv
// Directed bench for ovl_width_mc with default parameters (4 ch, MIN=3, MAX=5).
module tb_ovl_width_mc;

  localparam int NCH = 4;
  localparam int EW  = 3 * NCH + 1;

  logic              clock;
  logic              reset;
  logic              enable;
  logic [NCH-1:0]    test_expr;
  logic              clr_status;
  logic [NCH-1:0]    fire_min;
  logic [NCH-1:0]    fire_max;
  logic              fire;
  logic [NCH-1:0]    err_status;
  logic [NCH*16-1:0] cov_pulses;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic           rst;
    logic           en;
    logic [NCH-1:0] te;
    logic           clr;
    logic [NCH-1:0] fmin;
    logic [NCH-1:0] fmax;
    logic [NCH-1:0] err;
    logic [15:0]    cov2;
  } vec_t;

  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];

  ovl_width_mc dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .test_expr  (test_expr),
    .clr_status (clr_status),
    .fire_min   (fire_min),
    .fire_max   (fire_max),
    .fire       (fire),
    .err_status (err_status),
    .cov_pulses (cov_pulses)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic rst, input logic en, input logic [NCH-1:0] te,
                      input logic clr);
    @(negedge clock);
    reset      = rst;
    enable     = en;
    test_expr  = te;
    clr_status = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic en, input logic [NCH-1:0] te,
                     input logic clr, input logic [NCH-1:0] fmin,
                     input logic [NCH-1:0] fmax, input logic [NCH-1:0] err,
                     input logic [15:0] cov2);
    vec_t v;
    v.rst = rst; v.en = en; v.te = te; v.clr = clr;
    v.fmin = fmin; v.fmax = fmax; v.err = err; v.cov2 = cov2;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Only channel 2 ever ends a legal pulse in the table.
  function automatic logic [63:0] exp_cov(input logic [15:0] c2);
`ifdef OVL_WIDTH_COV_EN
    return {16'h0, c2, 16'h0, 16'h0};
`else
    return 64'(c2) & 64'h0;
`endif
  endfunction

  function automatic logic [EW-1:0] pack_exp(input logic [NCH-1:0] fmin,
                                             input logic [NCH-1:0] fmax,
                                             input logic [NCH-1:0] err);
    return {fmin, fmax, |{fmin, fmax}, err};
  endfunction

  task automatic check_outs(input string tag, input logic [EW-1:0] e);
    check({tag, ".fire_min"},   64'(fire_min),   64'(e[EW-1 -: NCH]));
    check({tag, ".fire_max"},   64'(fire_max),   64'(e[2*NCH : NCH+1]));
    check({tag, ".fire"},       64'(fire),       64'(e[NCH]));
    check({tag, ".err_status"}, 64'(err_status), 64'(e[NCH-1:0]));
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; test_expr = '0; clr_status = 1'b0;

    //   rst en te    clr fmin  fmax  err   cov2
    // 1. reset with all lines high; counting starts at W=1 after release
    add(1, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 0);
    add(1, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 0, 4'hF, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'hF, 0);
    add(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0);
    // 2. ch0 short pulse
    add(0, 1, 4'h1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 0, 4'h1, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h1, 0);
    add(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    // 3. ch1 high 8 clocks, fire_max after the 6th sample only
    for (int i = 0; i < 5; i++) add(0, 1, 4'h2, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h2, 0, 4'h0, 4'h2, 4'h0, 0);
    add(0, 1, 4'h2, 0, 4'h0, 4'h0, 4'h2, 0);
    add(0, 1, 4'h2, 0, 4'h0, 4'h0, 4'h2, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h2, 0);
    add(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    // 4. ch2 legal 3, one low, back-to-back legal 5
    for (int i = 0; i < 3; i++) add(0, 1, 4'h4, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 4'h4, 0, 4'h0, 4'h0, 4'h0, 1);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2);
    // 5. ch0 short + ch3 long aligned; clear on ch3 fire cycle keeps bit 3
    add(0, 1, 4'h9, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 1, 4'h9, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 1, 4'h8, 0, 4'h1, 4'h0, 4'h0, 2);
    add(0, 1, 4'h8, 0, 4'h0, 4'h0, 4'h1, 2);
    add(0, 1, 4'h8, 0, 4'h0, 4'h0, 4'h1, 2);
    add(0, 1, 4'h8, 0, 4'h0, 4'h8, 4'h1, 2);
    add(0, 1, 4'h8, 1, 4'h0, 4'h0, 4'h8, 2);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h8, 2);
    add(0, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 2);
    // 6. enable dropped on ch1 after 4 highs, re-count from W=1
    for (int i = 0; i < 4; i++) add(0, 1, 4'h2, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 0, 4'h2, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 0, 4'h2, 0, 4'h0, 4'h0, 4'h0, 2);
    for (int i = 0; i < 5; i++) add(0, 1, 4'h2, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 1, 4'h2, 0, 4'h0, 4'h2, 4'h0, 2);
    add(0, 1, 4'h2, 0, 4'h0, 4'h0, 4'h2, 2);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h2, 2);
    // short pulse ending while disabled is discarded
    add(0, 1, 4'h1, 1, 4'h0, 4'h0, 4'h0, 2);
    add(0, 1, 4'h1, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2);

    foreach (vecs[i]) begin
      exp_q.push_back(pack_exp(vecs[i].fmin, vecs[i].fmax, vecs[i].err));
      step(vecs[i].rst, vecs[i].en, vecs[i].te, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), exp_q.pop_front());
      check($sformatf("vec%0d.cov_pulses", i), cov_pulses, exp_cov(vecs[i].cov2));
    end

    // All four channels exceed MAX together: one shared 1-cycle fire.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'hF, 0);
      check_outs($sformatf("all_max_w%0d", i + 1), pack_exp(4'h0, 4'h0, 4'h0));
    end
    step(0, 1, 4'hF, 0);
    check_outs("all_max_fire", pack_exp(4'h0, 4'hF, 4'h0));
    step(0, 1, 4'hF, 0);
    check_outs("all_max_after", pack_exp(4'h0, 4'h0, 4'hF));
    step(0, 1, 4'h0, 0);
    check_outs("all_max_fall", pack_exp(4'h0, 4'h0, 4'hF));
    step(0, 1, 4'h0, 1);
    check_outs("all_max_clr", pack_exp(4'h0, 4'h0, 4'h0));

    // Reset in the middle of a short pulse abandons it silently.
    step(0, 1, 4'h1, 0);
    step(0, 1, 4'h1, 0);
    step(1, 1, 4'h0, 0);
    check_outs("rst_mid_pulse", pack_exp(4'h0, 4'h0, 4'h0));
    check("rst_mid_pulse.cov_pulses", cov_pulses, 64'h0);
    step(0, 1, 4'h0, 0);
    check_outs("rst_after", pack_exp(4'h0, 4'h0, 4'h0));

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
